// File: rtl/s32x_fb_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : S32X_PKG
//  Purpose  : Shared types and constants for the 32X frame-buffer memory stage
//  Revision : 1.0 - initial release
// ============================================================================
package S32X_PKG;

    // Number of VDP frame-buffer ports served by the controller
    localparam int FB_PORT_CNT = 2;

    // Address width carried in a queued request; the controller's AW
    // parameter must not exceed this value.
    localparam int FB_AW = 16;

    // One queued frame-buffer access
    typedef struct packed {
        logic [FB_AW-1:0] A;    // word address within the bank
        logic [15:0]      D;    // write data
        logic [1:0]       WE;   // byte write enables {upper,lower}
        logic             WR;   // 1 = write, 0 = read
    } FB_REQ_t;

    // Memory-channel sequencing states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        RDWAIT = 2'd2
    } FB_CTRL_STATE_t;

endpackage
`default_nettype wire

// File: rtl/s32x_fb_req_queue.sv
`default_nettype none
// ============================================================================
//  Module   : s32x_fb_req_queue
//  Purpose  : Per-port request detector (edge/change based) feeding a small
//             FIFO with empty status and a one-cycle overflow pulse
//  Revision : 1.0 - initial release
// ============================================================================
module s32x_fb_req_queue
    import S32X_PKG::*;
#(
    parameter int QDEPTH = 2,
    parameter int AW     = 16
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [AW-1:0] i_a,
    input  logic [15:0]   i_di,
    input  logic [1:0]    i_we,
    input  logic          i_rd,
    input  logic          i_pop,
    output FB_REQ_t       o_head,
    output logic          o_empty,
    output logic          o_ovf
);

    localparam int             c_PW       = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam logic [c_PW:0]  c_FULL_CNT = (c_PW + 1)'(QDEPTH);

    logic [AW-1:0]   r_prev_a;
    logic [15:0]     r_prev_di;
    logic [1:0]      r_prev_we;
    logic            r_prev_rd;

    logic [c_PW-1:0] r_wr_ptr;
    logic [c_PW-1:0] r_rd_ptr;
    logic [c_PW:0]   r_cnt;
    FB_REQ_t         r_mem [QDEPTH];

    logic            w_wr_req;
    logic            w_rd_req;
    logic            w_new;
    logic            w_full;
    logic            w_empty;
    logic            w_do_pop;
    logic            w_do_push;
    FB_REQ_t         w_entry;

    // Change detection against last cycle's inputs; a write wins over a read
    always_comb begin
        w_wr_req = (i_we != 2'b00) &&
                   ((r_prev_we == 2'b00) || (i_a != r_prev_a) ||
                    (i_di != r_prev_di) || (i_we != r_prev_we));
        w_rd_req = i_rd && (i_we == 2'b00) && (!r_prev_rd || (i_a != r_prev_a));
        w_new    = w_wr_req || w_rd_req;

        w_full    = (r_cnt == c_FULL_CNT);
        w_empty   = (r_cnt == '0);
        w_do_pop  = i_pop && !w_empty;
        // A pop in the same cycle frees the slot, so a full queue still accepts
        w_do_push = w_new && (!w_full || w_do_pop);

        w_entry    = '0;
        w_entry.A  = FB_AW'(i_a);
        w_entry.D  = i_di;
        w_entry.WE = i_we;
        w_entry.WR = w_wr_req;
    end

    // Previous-cycle copy of the port inputs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_prev_a  <= '0;
            r_prev_di <= '0;
            r_prev_we <= '0;
            r_prev_rd <= 1'b0;
        end else begin
            r_prev_a  <= i_a;
            r_prev_di <= i_di;
            r_prev_we <= i_we;
            r_prev_rd <= i_rd;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // FIFO storage; contents are don't-care while the slot is empty
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_empty = w_empty;
    assign o_ovf   = w_new && w_full && !w_do_pop;

endmodule
`default_nettype wire

// File: rtl/s32x_fb_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : s32x_fb_ctrl
//  Purpose  : Serialises the two 32X VDP frame-buffer ports onto one 16-bit
//             external memory channel with round-robin arbitration, a single
//             outstanding read and registered per-port read data
//  Revision : 1.0 - initial release
// ============================================================================
module s32x_fb_ctrl
    import S32X_PKG::*;
#(
    parameter int QDEPTH = 2,
    parameter int AW     = 16
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [AW-1:0] FB0_A,
    input  logic [15:0]   FB0_DI,
    input  logic [1:0]    FB0_WE,
    input  logic          FB0_RD,
    output logic [15:0]   FB0_Q,
    input  logic [AW-1:0] FB1_A,
    input  logic [15:0]   FB1_DI,
    input  logic [1:0]    FB1_WE,
    input  logic          FB1_RD,
    output logic [15:0]   FB1_Q,
    output logic [AW:0]   MEM_A,
    output logic [15:0]   MEM_D,
    output logic [1:0]    MEM_BE,
    output logic          MEM_WE,
    output logic          MEM_REQ,
    input  logic          MEM_ACK,
    input  logic [15:0]   MEM_Q,
    input  logic          MEM_QV,
    output logic [1:0]    OVF
);

    FB_CTRL_STATE_t r_state;
    FB_CTRL_STATE_t w_state_nxt;

    FB_REQ_t        w_head [FB_PORT_CNT];
    FB_REQ_t        w_sel;
    logic [FB_PORT_CNT-1:0] w_empty;
    logic [FB_PORT_CNT-1:0] w_ovf;
    logic [FB_PORT_CNT-1:0] w_pop;
    logic           w_grant;
    logic           w_gnt_port;
    logic           w_contested;

    logic           r_last_gnt;     // port that won the last contested grant
    logic           r_cur_port;     // port owning the access in flight
    logic           r_cur_wr;
    logic [AW:0]    r_mem_a;
    logic [15:0]    r_mem_d;
    logic [1:0]     r_mem_be;
    logic           r_mem_we;
    logic           r_mem_req;
    logic [15:0]    r_fbq [FB_PORT_CNT];
    logic [1:0]     r_ovf;

    s32x_fb_req_queue #(
        .QDEPTH (QDEPTH),
        .AW     (AW)
    ) u_q0 (
        .i_clk   (CLK),
        .i_rst   (RST),
        .i_a     (FB0_A),
        .i_di    (FB0_DI),
        .i_we    (FB0_WE),
        .i_rd    (FB0_RD),
        .i_pop   (w_pop[0]),
        .o_head  (w_head[0]),
        .o_empty (w_empty[0]),
        .o_ovf   (w_ovf[0])
    );

    s32x_fb_req_queue #(
        .QDEPTH (QDEPTH),
        .AW     (AW)
    ) u_q1 (
        .i_clk   (CLK),
        .i_rst   (RST),
        .i_a     (FB1_A),
        .i_di    (FB1_DI),
        .i_we    (FB1_WE),
        .i_rd    (FB1_RD),
        .i_pop   (w_pop[1]),
        .o_head  (w_head[1]),
        .o_empty (w_empty[1]),
        .o_ovf   (w_ovf[1])
    );

    // Arbitration and next-state; grants are only made from IDLE
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_gnt_port  = 1'b0;
        w_pop       = '0;
        w_contested = !w_empty[0] && !w_empty[1];
        case (r_state)
            IDLE: begin
                if (w_empty != 2'b11) begin
                    w_grant     = 1'b1;
                    w_gnt_port  = w_contested ? ~r_last_gnt : w_empty[0];
                    w_pop       = w_gnt_port ? 2'b10 : 2'b01;
                    w_state_nxt = REQ;
                end
            end
            REQ: begin
                if (MEM_ACK) begin
                    w_state_nxt = r_cur_wr ? IDLE : RDWAIT;
                end
            end
            RDWAIT: begin
                if (MEM_QV) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        w_sel = w_gnt_port ? w_head[1] : w_head[0];
    end

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Issue registers: loaded on grant, held until the request is accepted
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_mem_a    <= '0;
            r_mem_d    <= '0;
            r_mem_be   <= '0;
            r_mem_we   <= 1'b0;
            r_mem_req  <= 1'b0;
            r_cur_port <= 1'b0;
            r_cur_wr   <= 1'b0;
            r_last_gnt <= 1'b0;
        end else if (w_grant) begin
            r_mem_a    <= {w_gnt_port, AW'(w_sel.A)};
            r_mem_d    <= w_sel.D;
            r_mem_be   <= w_sel.WR ? w_sel.WE : 2'b11;
            r_mem_we   <= w_sel.WR;
            r_mem_req  <= 1'b1;
            r_cur_port <= w_gnt_port;
            r_cur_wr   <= w_sel.WR;
            if (w_contested) begin
                r_last_gnt <= w_gnt_port;
            end
        end else if ((r_state == REQ) && MEM_ACK) begin
            r_mem_req <= 1'b0;
        end
    end

    // Read return: only the issuing port's data register is updated
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < FB_PORT_CNT; i++) begin
                r_fbq[i] <= '0;
            end
        end else if ((r_state == RDWAIT) && MEM_QV) begin
            r_fbq[r_cur_port] <= MEM_Q;
        end
    end

    // Sticky overflow flags, cleared only by reset
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_ovf <= '0;
        end else begin
            r_ovf <= r_ovf | w_ovf;
        end
    end

    assign FB0_Q   = r_fbq[0];
    assign FB1_Q   = r_fbq[1];
    assign MEM_A   = r_mem_a;
    assign MEM_D   = r_mem_d;
    assign MEM_BE  = r_mem_be;
    assign MEM_WE  = r_mem_we;
    assign MEM_REQ = r_mem_req;
    assign OVF     = r_ovf;

endmodule
`default_nettype wire

// File: doc/s32x_fb_ctrl.md
Name: s32x_fb_ctrl

Overview:
- Downstream memory stage for the 32X VDP frame-buffer ports.
- Takes the two frame-buffer ports (FB0, FB1), each carrying display reads or draw/fill accesses, and serialises them onto one shared 16-bit external memory channel (SDRAM/BRAM bridge).
- Bank select is the top memory address bit.
- Provides registered per-port read data and decoupling queues, so VDP timing (dot-rate display reads, 4-wait draw accesses, fill bursts) survives a variable-latency memory.

Parameters:
QDEPTH, 2, request queue depth per port (power of two, >=2)
AW, 16, frame-buffer word address width per bank

Ports:
CLK  in  1  system clock
RST  in  1  reset, asynchronous, active-high
FB0_A  in  AW  FB0 word address
FB0_DI  in  16  FB0 write data
FB0_WE  in  2  FB0 byte write enables {upper,lower}
FB0_RD  in  1  FB0 read strobe
FB0_Q  out  16  FB0 last read data
FB1_A  in  AW  FB1 word address
FB1_DI  in  16  FB1 write data
FB1_WE  in  2  FB1 byte write enables
FB1_RD  in  1  FB1 read strobe
FB1_Q  out  16  FB1 last read data
MEM_A  out  AW+1  {bank, word address}; bank 0 = FB0
MEM_D  out  16  write data
MEM_BE  out  2  byte enables
MEM_WE  out  1  1 = write, 0 = read
MEM_REQ  out  1  request valid
MEM_ACK  in  1  request accepted this cycle
MEM_Q  in  16  read data
MEM_QV  in  1  read data valid, one-cycle pulse
OVF  out  2  sticky per-port queue-overflow flag

Behaviour:
- Reset values: FBx_Q=0, MEM_REQ=0, MEM_WE=0, MEM_A=0, MEM_D=0, MEM_BE=0, OVF=0. Queues empty; FSM in IDLE; round-robin pointer = FB0.
- Request detection, per port, compares inputs against the previous-cycle registered copy:
  - Write: WE!=0 and (prev WE==0, or A, DI or WE changed).
  - Read: RD=1 and WE==0 and (prev RD=0, or A changed).
  - RD and WE both set: write only; read ignored.
- Queue write: on the edge where a new request is sampled, push {A, DI, WE, is_write} into that port's queue.
- Queue full: the request is dropped and OVF[x] is set. OVF clears only on reset.
- Arbiter:
  - Evaluated in IDLE only.
  - If one queue is non-empty, grant it.
  - If both are non-empty, grant the port not granted last, then update the pointer.
- Issue: on the grant edge, pop the queue head and register MEM_A/D/BE/WE. MEM_REQ rises on that same edge (first visible one cycle after the request was sampled, when the queue was empty and the FSM idle).
- FSM states:
  - IDLE: any queue non-empty -> REQ.
  - REQ: MEM_REQ=1; all MEM_* fields held stable until MEM_ACK=1 is sampled. On ACK, MEM_REQ drops on that edge. Write -> IDLE. Read -> RDWAIT.
  - RDWAIT: on the edge MEM_QV=1 is sampled, latch MEM_Q into FBx_Q of the issuing port, then -> IDLE.
- Outstanding reads: at most one. No new issue until read data returns.
- Best-case throughput: one access per 2 cycles for writes with ACK in the first REQ cycle. Reads take 2 + memory latency cycles.
- Read return: FBx_Q changes only on read completion for that port and is held otherwise. The other port's Q is unaffected.
- Ordering: strictly in order per port, so read-after-write to the same address returns the new data. No ordering between ports.
- MEM_BE equals the queued WE for writes and 2'b11 for reads.
- MEM_QV sampled outside RDWAIT is ignored.
- Same-cycle events: push and pop on the same queue in one cycle are both honoured. Count is unchanged; full+pop+push is not an overflow.
- Async reset mid-transaction: FSM returns to IDLE, queues clear, MEM_REQ drops immediately. A late MEM_QV is ignored.
- Address arithmetic: no wrap logic. MEM_A = {port index, queued A}.

Decomposition:
- Shared package S32X_PKG gets:
  - FB_REQ_t (A[AW-1:0], D[15:0], WE[1:0], WR).
  - FB_CTRL_STATE_t enum {IDLE, REQ, RDWAIT}.
  - FB_PORT_CNT = 2 constant.
- One sub-module: s32x_fb_req_queue. Holds the change detector plus the QDEPTH FIFO with full/empty and the overflow pulse. Instantiated once per port.
- Arbiter, FSM and read-return mux stay in the top module.

Test Plan:
- FB0_RD pulse with FB0_A=0x0123, memory latency 3 -> MEM_REQ one cycle later with MEM_A=0x00123, MEM_WE=0, MEM_BE=11. FB0_Q=memory word on the edge after MEM_QV. FB1_Q stays 0.
- FB1_WE=01, FB1_A=0x0040, FB1_DI=0xAB55 -> single write: MEM_A=0x10040, MEM_D=0xAB55, MEM_BE=01. A held WE with unchanged inputs produces no second request.
- FB0 read and FB1 write sampled on the same edge, pointer at FB0 -> FB1 issued first, then FB0. Repeating the pair alternates the order.
- Three FB1 writes on consecutive cycles with MEM_ACK held low, QDEPTH=2 -> first issued (held in REQ), next two queued. A fourth write sets OVF[1]. After ACKs resume, exactly 3 writes appear, in order.
- FB0_RD held high while FB0_A steps 0x10, 0x11, 0x12 every 8 cycles -> three reads issued. FB0_Q tracks each returned word.
- RST asserted during RDWAIT, then MEM_QV pulses -> MEM_REQ=0 immediately, FB0_Q stays 0, queues empty, OVF=0.
